// File: rtl/axi4_slave_mem.sv
// AXI4 responder backed by a word-addressed register array.
// The write and read channels have independent FSMs, each with one outstanding burst.
module axi4_slave_mem #(
  parameter            P_BASE_ADDR  = 32'h10000000,
  parameter int        P_ID_WIDTH   = 4,
  parameter int        P_ADDR_WIDTH = 32,
  parameter int        P_DATA_WIDTH = 32,
  parameter int        P_MEM_DEPTH  = 256
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic [P_ID_WIDTH-1:0]     AWID,
  input  logic [P_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]                AWLEN,
  input  logic [2:0]                AWSIZE,
  input  logic [1:0]                AWBURST,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [P_DATA_WIDTH-1:0]   WDATA,
  input  logic [P_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                      WLAST,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [P_ID_WIDTH-1:0]     BID,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [P_ID_WIDTH-1:0]     ARID,
  input  logic [P_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]                ARLEN,
  input  logic [2:0]                ARSIZE,
  input  logic [1:0]                ARBURST,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [P_ID_WIDTH-1:0]     RID,
  output logic [P_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                RRESP,
  output logic                      RLAST,
  output logic                      RVALID,
  input  logic                      RREADY
);

  localparam int unsigned BYTES   = P_DATA_WIDTH / 8;
  localparam int unsigned BYTE_LG = $clog2(BYTES);
  localparam int unsigned IDX_W   = $clog2(P_MEM_DEPTH);
  localparam logic [P_ADDR_WIDTH-1:0] BASE      = P_ADDR_WIDTH'(P_BASE_ADDR);
  localparam logic [P_ADDR_WIDTH-1:0] MEM_BYTES = P_ADDR_WIDTH'(P_MEM_DEPTH * BYTES);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  logic [P_DATA_WIDTH-1:0] mem [P_MEM_DEPTH];

  function automatic logic addr_ok(input logic [P_ADDR_WIDTH-1:0] a);
    logic [P_ADDR_WIDTH-1:0] off;
    off = a - BASE;
    return (a >= BASE) && (off < MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [P_ADDR_WIDTH-1:0] a);
    logic [P_ADDR_WIDTH-1:0] off;
    off = (a - BASE) >> BYTE_LG;
    return IDX_W'(off);
  endfunction

  // FIXED bursts step by zero so the same word is hit every beat
  function automatic logic [P_ADDR_WIDTH-1:0] step_of(input logic [1:0] burst, input logic [2:0] size);
    return (burst == 2'b01) ? (P_ADDR_WIDTH'(1) << size) : '0;
  endfunction

  function automatic logic req_bad(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] || (size > 3'(BYTE_LG));
  endfunction

  // ---------------- write channel ----------------
  w_state_t                w_state, w_state_next;
  logic [P_ID_WIDTH-1:0]   w_id;
  logic [P_ADDR_WIDTH-1:0] w_addr, w_step;
  logic [7:0]              w_len, w_cnt;
  logic                    w_bad, w_err;
  logic                    w_beat, w_beat_ok, w_last_beat, w_beat_err;

  // Per-beat write qualification
  always_comb begin
    w_beat      = (w_state == W_DATA) && WVALID && WREADY;
    w_beat_ok   = !w_bad && addr_ok(w_addr);
    w_last_beat = (w_cnt == w_len);
    w_beat_err  = !w_beat_ok || (WLAST != w_last_beat);
  end

  // Write FSM next state
  always_comb begin
    w_state_next = w_state;
    case (w_state)
      W_IDLE:  if (AWVALID && AWREADY) w_state_next = W_DATA;
      W_DATA:  if (w_beat && w_last_beat) w_state_next = W_RESP;
      W_RESP:  if (BVALID && BREADY) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  // Write FSM state, registered handshake outputs and burst context
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= '0;
      w_id    <= '0;
      w_addr  <= '0;
      w_step  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_bad   <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_state_next;
      AWREADY <= (w_state_next == W_IDLE);
      WREADY  <= (w_state_next == W_DATA);
      BVALID  <= (w_state_next == W_RESP);
      if (w_state == W_IDLE && AWVALID && AWREADY) begin
        w_id   <= AWID;
        w_addr <= AWADDR;
        w_step <= step_of(AWBURST, AWSIZE);
        w_len  <= AWLEN;
        w_bad  <= req_bad(AWBURST, AWSIZE);
        w_cnt  <= '0;
        w_err  <= 1'b0;
      end
      if (w_beat) begin
        w_cnt  <= w_cnt + 8'd1;
        w_err  <= w_err | w_beat_err;
        w_addr <= w_addr + w_step;
        if (w_last_beat) begin
          BID   <= w_id;
          BRESP <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // Byte-enabled array write; contents survive reset
  always_ff @(posedge CLOCK) begin
    if (!RESET && w_beat && w_beat_ok) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t                r_state, r_state_next;
  logic [P_ADDR_WIDTH-1:0] r_addr, r_step, ld_addr;
  logic [7:0]              r_len, r_cnt;
  logic                    r_bad, ld_bad, ld_ok;
  logic                    ar_hs, r_hs;
  logic [P_DATA_WIDTH-1:0] rd_word;

  // Beat load source: the AR request on its handshake, else the running burst
  always_comb begin
    ar_hs   = (r_state == R_IDLE) && ARVALID && ARREADY;
    r_hs    = (r_state == R_DATA) && RVALID && RREADY;
    ld_addr = ar_hs ? ARADDR : r_addr;
    ld_bad  = ar_hs ? req_bad(ARBURST, ARSIZE) : r_bad;
    ld_ok   = !ld_bad && addr_ok(ld_addr);
    rd_word = ld_ok ? mem[word_idx(ld_addr)] : '0;
  end

  // Read FSM next state
  always_comb begin
    r_state_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_next = R_DATA;
      R_DATA:  if (r_hs && RLAST) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read FSM state and registered beat outputs
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= '0;
      r_addr  <= '0;
      r_step  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= r_state_next;
      ARREADY <= (r_state_next == R_IDLE);
      if (ar_hs) begin
        RID    <= ARID;
        r_len  <= ARLEN;
        r_step <= step_of(ARBURST, ARSIZE);
        r_bad  <= ld_bad;
        r_cnt  <= '0;
        r_addr <= ARADDR + step_of(ARBURST, ARSIZE);
        RVALID <= 1'b1;
        RLAST  <= (ARLEN == 8'd0);
        RDATA  <= rd_word;
        RRESP  <= ld_ok ? 2'b00 : 2'b10;
      end else if (r_hs) begin
        if (RLAST) begin
          RVALID <= 1'b0;
          RLAST  <= 1'b0;
        end else begin
          r_cnt  <= r_cnt + 8'd1;
          r_addr <= r_addr + r_step;
          RLAST  <= ((r_cnt + 8'd1) == r_len);
          RDATA  <= rd_word;
          RRESP  <= ld_ok ? 2'b00 : 2'b10;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Scoreboard bench for axi4_slave_mem: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them on each handshake.
module tb_axi4_slave_mem;

  logic        clk = 1'b0;
  logic        RESET;
  logic [3:0]  AWID, BID, ARID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int r_beat = 0;
  logic consec = 1'b0;

  logic [5:0]  b_q[$];   // {id, resp}
  logic [38:0] r_q[$];   // {id, data, resp, last}
  logic [5:0]  b_e;
  logic [38:0] r_e;

  axi4_slave_mem #(
    .P_BASE_ADDR(32'h10000000), .P_ID_WIDTH(4), .P_ADDR_WIDTH(32),
    .P_DATA_WIDTH(32), .P_MEM_DEPTH(256)
  ) dut (
    .CLOCK(clk), .RESET(RESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare responses at every handshake, sampled mid-cycle
  always @(negedge clk) begin
    if (!RESET && BVALID && BREADY) begin
      if (b_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL b_unexpected: got BID=0x%0h BRESP=0x%0h, expected no response", BID, BRESP);
      end else begin
        b_e = b_q.pop_front();
        chk("bid", 64'(BID), 64'(b_e[5:2]));
        chk("bresp", 64'(BRESP), 64'(b_e[1:0]));
      end
    end
    if (!RESET && RVALID && RREADY) begin
      if (r_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL r_unexpected: got RDATA=0x%0h, expected no beat", RDATA);
      end else begin
        r_e = r_q.pop_front();
        chk("rid", 64'(RID), 64'(r_e[38:35]));
        chk("rdata", 64'(RDATA), 64'(r_e[34:3]));
        chk("rresp", 64'(RRESP), 64'(r_e[2:1]));
        chk("rlast", 64'(RLAST), 64'(r_e[0]));
        if (consec && r_beat > 0) chk("r_consecutive", 64'(cyc - last_cyc), 64'd1);
        last_cyc = cyc;
        r_beat++;
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic [31:0] d0,
                          input logic [31:0] inc, input logic [3:0] strb, input logic [1:0] exp_resp,
                          input int wlast_at, input int stall, input int abort_after);
    int t;
    if (abort_after < 0) b_q.push_back({id, exp_resp});
    BREADY = (stall == 0);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) chk("aw_timeout", 64'(AWREADY), 64'd1);
    @(posedge clk); #1;
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == abort_after) begin
        WVALID = 1'b0; WLAST = 1'b0; RESET = 1'b1;
        @(posedge clk); #1;
        chk("rst_awready", 64'(AWREADY), 64'd0);
        chk("rst_wready", 64'(WREADY), 64'd0);
        chk("rst_bvalid", 64'(BVALID), 64'd0);
        chk("rst_arready", 64'(ARREADY), 64'd0);
        chk("rst_rvalid", 64'(RVALID), 64'd0);
        RESET = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_awready", 64'(AWREADY), 64'd1);
        BREADY = 1'b1;
        return;
      end
      WDATA = d0 + inc * 32'(i); WSTRB = strb; WLAST = (i == wlast_at); WVALID = 1'b1;
      t = 0;
      while (!WREADY && t < 50) begin @(posedge clk); #1; t++; end
      if (t >= 50) chk("w_timeout", 64'(WREADY), 64'd1);
      @(posedge clk); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    t = 0;
    while (!BVALID && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) chk("b_timeout", 64'(BVALID), 64'd1);
    for (int k = 0; k < stall; k++) begin
      chk("stall_bvalid", 64'(BVALID), 64'd1);
      chk("stall_bid", 64'(BID), 64'(id));
      chk("stall_awready", 64'(AWREADY), 64'd0);
      @(posedge clk); #1;
    end
    BREADY = 1'b1;
    t = 0;
    while (BVALID && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) chk("b_done_timeout", 64'(BVALID), 64'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                         input logic [1:0] burst, input logic [31:0] d0, input logic [31:0] inc,
                         input int err_from, input logic toggle);
    int t;
    for (int i = 0; i <= int'(len); i++) begin
      if (i >= err_from) r_q.push_back({id, 32'h0, 2'b10, 1'(i == int'(len))});
      else r_q.push_back({id, d0 + inc * 32'(i), 2'b00, 1'(i == int'(len))});
    end
    consec = !toggle; r_beat = 0; RREADY = !toggle;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = burst; ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) chk("ar_timeout", 64'(ARREADY), 64'd1);
    @(posedge clk); #1;
    ARVALID = 1'b0;
    t = 0;
    while (r_q.size() > 0 && t < 300) begin
      @(posedge clk); #1;
      if (toggle) RREADY = ~RREADY;
      t++;
    end
    if (t >= 300) chk("r_timeout_left", 64'(r_q.size()), 64'd0);
    chk("r_end_arready", 64'(ARREADY), 64'd1);
    chk("r_end_rvalid", 64'(RVALID), 64'd0);
    RREADY = 1'b1; consec = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 1; RREADY = 1;
    AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; WDATA = 0; WSTRB = 0; WLAST = 0;
    ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_awready", 64'(AWREADY), 64'd0);
    chk("reset_arready", 64'(ARREADY), 64'd0);
    chk("reset_wready", 64'(WREADY), 64'd0);
    chk("reset_bvalid", 64'(BVALID), 64'd0);
    chk("reset_rvalid", 64'(RVALID), 64'd0);
    chk("reset_outs", {RDATA, 26'(0), RLAST, RRESP, BRESP, BID[0]}, 64'd0);
    RESET = 1'b0;
    @(posedge clk); #1;
    chk("release_awready", 64'(AWREADY), 64'd1);
    chk("release_arready", 64'(ARREADY), 64'd1);

    // single beat write/read
    do_write(32'h10000000, 8'd0, 3'd2, 2'b01, 4'h3, 32'hF1, 32'd0, 4'hF, 2'b00, 0, 0, -1);
    do_read (32'h10000000, 8'd0, 4'h5, 2'b01, 32'hF1, 32'd0, 999, 1'b0);
    // 16-beat INCR, back-to-back read
    do_write(32'h10000040, 8'd15, 3'd2, 2'b01, 4'h1, 32'd0, 32'd1, 4'hF, 2'b00, 15, 0, -1);
    do_read (32'h10000040, 8'd15, 4'h7, 2'b01, 32'd0, 32'd1, 999, 1'b0);
    // partial strobes
    do_write(32'h10000010, 8'd0, 3'd2, 2'b01, 4'h2, 32'h11223344, 32'd0, 4'hF, 2'b00, 0, 0, -1);
    do_write(32'h10000010, 8'd0, 3'd2, 2'b01, 4'h2, 32'hAABBCCDD, 32'd0, 4'h3, 2'b00, 0, 0, -1);
    do_read (32'h10000010, 8'd0, 4'h2, 2'b01, 32'h1122CCDD, 32'd0, 999, 1'b0);
    // out-of-range write must not alias onto word 0
    do_write(32'h10000400, 8'd0, 3'd2, 2'b01, 4'h4, 32'h0000DEAD, 32'd0, 4'hF, 2'b10, 0, 0, -1);
    do_read (32'h10000000, 8'd0, 4'h4, 2'b01, 32'hF1, 32'd0, 999, 1'b0);
    // WRAP burst consumed, not written
    do_write(32'h10000010, 8'd1, 3'd2, 2'b10, 4'h8, 32'h55, 32'd0, 4'hF, 2'b10, 1, 0, -1);
    do_read (32'h10000010, 8'd0, 4'h8, 2'b01, 32'h1122CCDD, 32'd0, 999, 1'b0);
    // oversize AWSIZE
    do_write(32'h10000010, 8'd0, 3'd3, 2'b01, 4'h9, 32'h66, 32'd0, 4'hF, 2'b10, 0, 0, -1);
    // read straddling the top of memory
    do_write(32'h100003FC, 8'd0, 3'd2, 2'b01, 4'hA, 32'h3FC0FFEE, 32'd0, 4'hF, 2'b00, 0, 0, -1);
    do_read (32'h100003FC, 8'd1, 4'hA, 2'b01, 32'h3FC0FFEE, 32'd0, 1, 1'b0);
    // early WLAST flags SLVERR
    do_write(32'h10000030, 8'd1, 3'd2, 2'b01, 4'hB, 32'h9, 32'd1, 4'hF, 2'b10, 0, 0, -1);
    // FIXED burst keeps overwriting one word
    do_write(32'h10000020, 8'd2, 3'd2, 2'b00, 4'hC, 32'hA, 32'd1, 4'hF, 2'b00, 2, 0, -1);
    do_read (32'h10000020, 8'd0, 4'hC, 2'b01, 32'hC, 32'd0, 999, 1'b0);
    // backpressure on B and R
    do_write(32'h10000100, 8'd0, 3'd2, 2'b01, 4'hD, 32'h77, 32'd0, 4'hF, 2'b00, 0, 5, -1);
    do_read (32'h10000040, 8'd15, 4'hE, 2'b01, 32'd0, 32'd1, 999, 1'b1);
    // reset in the middle of an 8-beat write
    do_write(32'h10000080, 8'd7, 3'd2, 2'b01, 4'h6, 32'h100, 32'd1, 4'hF, 2'b00, 7, 0, 3);
    do_read (32'h10000080, 8'd2, 4'h6, 2'b01, 32'h100, 32'd1, 999, 1'b0);
    do_write(32'h10000080, 8'd7, 3'd2, 2'b01, 4'h6, 32'h200, 32'd1, 4'hF, 2'b00, 7, 0, -1);
    do_read (32'h10000080, 8'd7, 4'h6, 2'b01, 32'h200, 32'd1, 999, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("b_queue_empty", 64'(b_q.size()), 64'd0);
    chk("r_queue_empty", 64'(r_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi4_slave_mem.md
Name: axi4_slave_mem

Overview:
AXI4 full-protocol responder that terminates the write and read channels driven by axi4_master and backs them with an internal word-addressed register array. It is the synthesizable in-design counterpart to the simulation slave VIP, used as a scratch memory and as a loopback target for master bring-up. The write and read channels run independent state machines, with one outstanding transaction per channel.

Parameters:
P_BASE_ADDR, 32'h10000000, byte address of memory word 0
P_ID_WIDTH, 4, width of AWID/BID/ARID/RID
P_ADDR_WIDTH, 32, address width
P_DATA_WIDTH, 32, data width; legal values 32 or 64
P_MEM_DEPTH, 256, number of P_DATA_WIDTH words; must be a power of 2

Ports:
CLOCK  in  1  single clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
AWID  in  P_ID_WIDTH  write ID
AWADDR  in  P_ADDR_WIDTH  write start byte address
AWLEN  in  8  beats minus 1
AWSIZE  in  3  log2 bytes per beat
AWBURST  in  2  burst type
AWVALID  in  1  address valid
AWREADY  out  1  address accept
WDATA  in  P_DATA_WIDTH  write data
WSTRB  in  P_DATA_WIDTH/8  byte enables
WLAST  in  1  last write beat
WVALID  in  1  write data valid
WREADY  out  1  write data accept
BID  out  P_ID_WIDTH  response ID
BRESP  out  2  write response
BVALID  out  1  response valid
BREADY  in  1  response accept
ARID  in  P_ID_WIDTH  read ID
ARADDR  in  P_ADDR_WIDTH  read start byte address
ARLEN  in  8  beats minus 1
ARSIZE  in  3  log2 bytes per beat
ARBURST  in  2  burst type
ARVALID  in  1  address valid
ARREADY  out  1  address accept
RID  out  P_ID_WIDTH  read ID
RDATA  out  P_DATA_WIDTH  read data
RRESP  out  2  read response
RLAST  out  1  last read beat
RVALID  out  1  read data valid
RREADY  in  1  read data accept

Behaviour:
- Reset: synchronous, active-high, on CLOCK. While RESET is high, every output is 0.
- All outputs are registered. AWREADY and ARREADY rise on the first edge after RESET falls.
- Memory contents are not cleared by reset.
- Reset mid-burst: both FSMs go to IDLE and all valid/ready outputs drop on the next edge. Beats already written are retained.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, capture ID, ADDR, LEN, SIZE, BURST. Clear the beat counter and error flag. Go to W_DATA with AWREADY=0 and WREADY=1.
  - W_DATA: each WVALID&WREADY writes the bytes selected by WSTRB into word (addr-P_BASE_ADDR)>>log2(P_DATA_WIDTH/8), then advances the address.
    - INCR: address advances by 2^SIZE.
    - FIXED: address does not change.
  - When the beat counter reaches LEN: go to W_RESP, set WREADY=0, BVALID=1, BID=captured ID.
  - W_RESP: BVALID is held until BREADY, then return to W_IDLE with AWREADY=1.
- Write error flag (BRESP=2'b10 SLVERR, else 2'b00 OKAY). The flag is set by any of:
  - a beat address outside [P_BASE_ADDR, P_BASE_ADDR+P_MEM_DEPTH*P_DATA_WIDTH/8); the write for that beat is suppressed;
  - AWBURST=WRAP or reserved; the whole burst is consumed but not written;
  - AWSIZE > log2(P_DATA_WIDTH/8); the whole burst is consumed but not written;
  - WLAST not asserted on beat LEN, or asserted earlier. The burst always ends on the beat count, never on WLAST.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On the ARVALID&ARREADY edge, capture the request and load beat 0, with the same address rules as writes.
  - From the next cycle: RVALID=1, RID=ARID, RLAST=(LEN==0).
  - Memory read is asynchronous from the array. RDATA is registered, with one-cycle latency from the AR handshake.
  - On each RVALID&RREADY edge, the next beat is loaded in the same edge, giving one beat per cycle back-to-back.
  - On the last beat, RVALID drops, RLAST drops and ARREADY rises on the same edge.
  - While RVALID&!RREADY, RDATA, RRESP and RLAST stay stable.
- Read errors are reported per beat: an out-of-range beat, WRAP/reserved burst, or oversize ARSIZE gives RDATA=0 and RRESP=2'b10. All other beats give RRESP=2'b00.
- A read beat loaded on the same edge as a write to the same word returns the old data.
- Addresses are not checked against the 4 KB boundary. LOCK, CACHE, PROT and QOS are not ported and are tied off at integration.

Test Plan:
- Single write 0x10000000, LEN=0, SIZE=2, WDATA=0xF1, WSTRB=0xF, AWID=3 -> BRESP=00, BID=3. Read back -> RDATA=0xF1, RLAST=1, RRESP=00, RID=ARID.
- INCR write 0x10000040, LEN=15, data 0..15, then read with RREADY=1 -> 16 beats on consecutive cycles with data 0..15; RLAST only on beat 15; ARREADY high the following cycle.
- Write 0x11223344 to 0x10000010, then 0xAABBCCDD with WSTRB=4'b0011 -> readback 0x1122CCDD.
- AWADDR 0x10000400 (depth 256 x 4 B) -> BRESP=10, memory unchanged. AWBURST=WRAP -> BRESP=10. Read 0x100003FC with LEN=1 -> beat 0 RRESP=00, beat 1 RDATA=0 and RRESP=10.
- Backpressure: BREADY low for 5 cycles -> BVALID and BID hold, AWREADY stays 0. RREADY toggled each cycle -> RDATA stable while stalled, no beats dropped or duplicated.
- RESET pulse at beat 3 of an 8-beat write -> next edge all valid/ready outputs 0. After release, beats 0-2 read back correct, and a new burst completes with BRESP=00.
